// File: rtl/sof_receive_if.sv
// Packet-decoder / control-block side signals of the SOF receiver.
// frameNumErr is present only when SOF_FRAME_CHECK_EN is defined.
interface sof_receive_if;
    logic        SOFRxEnable;
    logic        fullSpeedRate;
    logic        RxPktValid;
    logic [3:0]  RxPID;
    logic [10:0] RxFrameNum;
    logic        RxCRCError;
    logic        RxBitStuffError;
    logic        missCountClr;
    logic [10:0] frameNum;
    logic        SOFRxed;
    logic        SOFMissed;
    logic        SOFLocked;
    logic [15:0] SOFTimer;
    logic [7:0]  SOFMissCount;
`ifdef SOF_FRAME_CHECK_EN
    logic        frameNumErr;
`endif

    modport master (
        output SOFRxEnable, fullSpeedRate, RxPktValid, RxPID, RxFrameNum,
               RxCRCError, RxBitStuffError, missCountClr,
`ifdef SOF_FRAME_CHECK_EN
        input  frameNumErr,
`endif
        input  frameNum, SOFRxed, SOFMissed, SOFLocked, SOFTimer, SOFMissCount
    );

    modport slave (
        input  SOFRxEnable, fullSpeedRate, RxPktValid, RxPID, RxFrameNum,
               RxCRCError, RxBitStuffError, missCountClr,
`ifdef SOF_FRAME_CHECK_EN
        output frameNumErr,
`endif
        output frameNum, SOFRxed, SOFMissed, SOFLocked, SOFTimer, SOFMissCount
    );
endinterface

// File: rtl/sof_receive.sv
// Device-side SOF receiver: latches frame numbers, times frames, tracks lock and misses.
// Optional macro SOF_FRAME_CHECK_EN adds frame-number continuity checking (frameNumErr).
module sof_receive #(
    parameter logic [15:0] FRAME_TICKS = 16'd48000,
    parameter logic [15:0] TOL         = 16'd48,
    parameter int unsigned MAX_MISS    = 3
) (
    input logic          clk,
    input logic          rst,
    sof_receive_if.slave bus
);
    localparam logic [15:0] EARLY  = FRAME_TICKS - TOL;
    localparam logic [15:0] LATE   = FRAME_TICKS + TOL;
    localparam int unsigned MISS_W = $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {DISABLED, SEARCH, TRACK, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [10:0]         frame_q, frame_d;
    logic [15:0]         timer_q, timer_d;
    logic                rxed_q, rxed_d;
    logic                missed_q, missed_d;
    logic                locked_q, locked_d;
    logic [7:0]          mcnt_q, mcnt_d;
    logic [MISS_W-1:0]   cons_q, cons_d;
`ifdef SOF_FRAME_CHECK_EN
    logic                err_q, err_d;
`endif

    logic                sof_valid, link_on, in_window, miss_event;
    logic [15:0]         timer_inc;
    logic [10:0]         frame_inc;
    logic [MISS_W-1:0]   cons_inc;

    assign sof_valid = bus.RxPktValid && (bus.RxPID == 4'h5)
                       && !bus.RxCRCError && !bus.RxBitStuffError;
    assign link_on   = bus.SOFRxEnable && bus.fullSpeedRate;
    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    assign in_window = (timer_q >= EARLY) && (timer_q <= LATE);
    assign frame_inc = frame_q + 11'd1;
    assign cons_inc  = cons_q + MISS_W'(1);

    // Next-state and output logic; a disable always wins, then SOF, then timeouts.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        timer_d    = timer_inc;
        rxed_d     = 1'b0;
        missed_d   = 1'b0;
        mcnt_d     = mcnt_q;
        cons_d     = cons_q;
        miss_event = 1'b0;
`ifdef SOF_FRAME_CHECK_EN
        err_d      = 1'b0;
`endif
        if (!link_on) begin
            state_d = DISABLED;
            timer_d = '0;
            cons_d  = '0;
        end else if (state_q == DISABLED) begin
            state_d = SEARCH;
            timer_d = '0;
        end else if (sof_valid) begin
            rxed_d  = 1'b1;
            frame_d = bus.RxFrameNum;
            timer_d = '0;
            cons_d  = '0;
            unique case (state_q)
                SEARCH: state_d = TRACK;
                TRACK:  if (in_window) state_d = LOCKED;
                LOCKED: begin
                    if (timer_q < EARLY) begin
                        state_d = TRACK;
                    end
`ifdef SOF_FRAME_CHECK_EN
                    else if (bus.RxFrameNum != frame_inc) begin
                        err_d   = 1'b1;
                        state_d = TRACK;
                    end
`endif
                end
                default: state_d = state_q;
            endcase
        end else if ((state_q == TRACK) && (timer_q >= LATE)) begin
            state_d = SEARCH;
        end else if ((state_q == LOCKED) && (timer_q == LATE)) begin
            // Missed SOF: advance to the predicted frame, timer restarts at predicted start.
            miss_event = 1'b1;
            missed_d   = 1'b1;
            frame_d    = frame_inc;
            timer_d    = TOL;
            cons_d     = cons_inc;
            if (cons_inc == MISS_W'(MAX_MISS)) begin
                state_d = SEARCH;
                cons_d  = '0;
            end
        end

        if (bus.missCountClr) begin
            mcnt_d = {7'd0, miss_event};
        end else if (miss_event && (mcnt_q != 8'hFF)) begin
            mcnt_d = mcnt_q + 8'd1;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DISABLED;
            frame_q  <= '0;
            timer_q  <= '0;
            rxed_q   <= 1'b0;
            missed_q <= 1'b0;
            locked_q <= 1'b0;
            mcnt_q   <= '0;
            cons_q   <= '0;
`ifdef SOF_FRAME_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            timer_q  <= timer_d;
            rxed_q   <= rxed_d;
            missed_q <= missed_d;
            locked_q <= locked_d;
            mcnt_q   <= mcnt_d;
            cons_q   <= cons_d;
`ifdef SOF_FRAME_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.frameNum     = frame_q;
    assign bus.SOFRxed      = rxed_q;
    assign bus.SOFMissed    = missed_q;
    assign bus.SOFLocked    = locked_q;
    assign bus.SOFTimer     = timer_q;
    assign bus.SOFMissCount = mcnt_q;
`ifdef SOF_FRAME_CHECK_EN
    assign bus.frameNumErr  = err_q;
`endif

endmodule

// File: tb/tb_sof_receive.sv
// Bench for sof_receive: directed vector table, hand sequences, and random SOF traffic
// checked every cycle against a timestamp-based reference model.
module tb_sof_receive;
    localparam int FT = 100;
    localparam int TL = 4;
    localparam int MM = 3;
    localparam int EARLY = FT - TL;
    localparam int LATE  = FT + TL;
    localparam int M_OFF = 0, M_SRCH = 1, M_TRK = 2, M_LCK = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sof_receive_if sif();
    sof_receive #(.FRAME_TICKS(16'(FT)), .TOL(16'(TL)), .MAX_MISS(MM))
        dut (.clk(clk), .rst(rst), .bus(sif.slave));

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // Reference model: the timer is "edges since the current frame start".
    int n_edges = 0, start = 0, mode = M_OFF, cons = 0, e_fn = 0, e_mcnt = 0;
    bit e_rxed = 1'b0, e_missed = 1'b0, e_err = 1'b0;

    always @(posedge clk) begin : model_step
        int  t;
        bit  sof, on, miss;
        n_edges = n_edges + 1;
        t = n_edges - 1 - start;
        if (t > 65535) t = 65535;
        sof  = sif.RxPktValid && (sif.RxPID == 4'h5) && !sif.RxCRCError && !sif.RxBitStuffError;
        on   = sif.SOFRxEnable && sif.fullSpeedRate;
        miss = 1'b0;
        e_rxed = 1'b0; e_missed = 1'b0; e_err = 1'b0;
        if (!rst) begin
            mode = M_OFF; start = n_edges; cons = 0; e_fn = 0; e_mcnt = 0;
        end else begin
            if (!on) begin
                mode = M_OFF; start = n_edges; cons = 0;
            end else if (mode == M_OFF) begin
                mode = M_SRCH; start = n_edges;
            end else if (sof) begin
                e_rxed = 1'b1; start = n_edges; cons = 0;
                if (mode == M_SRCH) mode = M_TRK;
                else if (mode == M_TRK) mode = (t >= EARLY && t <= LATE) ? M_LCK : M_TRK;
                else if (t < EARLY) mode = M_TRK;
`ifdef SOF_FRAME_CHECK_EN
                else if (int'(sif.RxFrameNum) != (e_fn + 1) % 2048) begin
                    e_err = 1'b1; mode = M_TRK;
                end
`endif
                e_fn = int'(sif.RxFrameNum);
            end else if (mode == M_TRK && t >= LATE) begin
                mode = M_SRCH;
            end else if (mode == M_LCK && t == LATE) begin
                miss = 1'b1; e_missed = 1'b1;
                e_fn = (e_fn + 1) % 2048;
                start = n_edges - TL;
                cons = cons + 1;
                if (cons >= MM) mode = M_SRCH;
            end
            if (sif.missCountClr) e_mcnt = miss ? 1 : 0;
            else if (miss && e_mcnt < 255) e_mcnt = e_mcnt + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : model_check
        int  t;
        bit  bad;
        if (chk_on) begin
            t = n_edges - start;
            if (t > 65535) t = 65535;
            bad = (sif.frameNum !== 11'(e_fn)) || (sif.SOFRxed !== e_rxed)
                  || (sif.SOFMissed !== e_missed) || (sif.SOFLocked !== (mode == M_LCK))
                  || (sif.SOFTimer !== 16'(t)) || (sif.SOFMissCount !== 8'(e_mcnt));
`ifdef SOF_FRAME_CHECK_EN
            bad = bad || (sif.frameNumErr !== e_err);
`endif
            vectors = vectors + 1;
            if (bad) begin
                miscompares = miscompares + 1;
                $display("FAIL model t=%0t got fn=%h rx=%b ms=%b lk=%b tmr=%0d mc=%0d want fn=%h rx=%b ms=%b lk=%b tmr=%0d mc=%0d",
                         $time, sif.frameNum, sif.SOFRxed, sif.SOFMissed, sif.SOFLocked, sif.SOFTimer,
                         sif.SOFMissCount, 11'(e_fn), e_rxed, e_missed, (mode == M_LCK), t, e_mcnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Wait gap cycles, present one cycle of inputs, land on the negedge after it is sampled.
    task automatic pkt(input int gap, input bit vld, input logic [3:0] pid, input logic [10:0] fnum,
                       input bit crc, input bit bse, input bit clr, input bit en, input bit fs);
        repeat (gap) @(negedge clk);
        sif.RxPktValid = vld; sif.RxPID = pid; sif.RxFrameNum = fnum;
        sif.RxCRCError = crc; sif.RxBitStuffError = bse; sif.missCountClr = clr;
        sif.SOFRxEnable = en; sif.fullSpeedRate = fs;
        @(negedge clk);
        sif.RxPktValid = 1'b0; sif.RxPID = 4'h0; sif.RxCRCError = 1'b0;
        sif.RxBitStuffError = 1'b0; sif.missCountClr = 1'b0;
    endtask

    typedef struct {
        int gap; bit vld; logic [3:0] pid; logic [10:0] fnum;
        bit crc, bse, clr, en, fs;
        bit x_rxed, x_missed, x_locked; logic [10:0] x_fn; int x_tmr; int x_mcnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int gap, input bit vld, input logic [3:0] pid, input logic [10:0] fnum,
                       input bit crc, input bit bse, input bit clr, input bit en, input bit fs,
                       input bit xr, input bit xm, input bit xl, input logic [10:0] xf,
                       input int xt, input int xc);
        vec_t v;
        v.gap = gap; v.vld = vld; v.pid = pid; v.fnum = fnum; v.crc = crc; v.bse = bse;
        v.clr = clr; v.en = en; v.fs = fs; v.x_rxed = xr; v.x_missed = xm; v.x_locked = xl;
        v.x_fn = xf; v.x_tmr = xt; v.x_mcnt = xc;
        tbl.push_back(v);
    endtask

    initial begin
        //   gap vld pid   fnum    crc bse clr en fs | rx ms lk fn      tmr  mc
        add(  3, 1, 4'h5, 11'h010, 0, 0, 0, 1, 1,   1, 0, 0, 11'h010,   0, 0);
        add(100, 1, 4'h5, 11'h011, 0, 0, 0, 1, 1,   1, 0, 1, 11'h011,   0, 0);
        add(104, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 1, 1, 11'h012,   4, 1);
        add(100, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 1, 1, 11'h013,   4, 2);
        add(100, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 1, 0, 11'h014,   4, 3);
        add( 10, 1, 4'h5, 11'h020, 0, 0, 0, 1, 1,   1, 0, 0, 11'h020,   0, 3);
        add(100, 1, 4'h5, 11'h021, 0, 0, 0, 1, 1,   1, 0, 1, 11'h021,   0, 3);
        add(100, 1, 4'h5, 11'h055, 1, 0, 0, 1, 1,   0, 0, 1, 11'h021, 101, 3);
        add(  2, 1, 4'h5, 11'h022, 0, 0, 0, 1, 1,   1, 0, 1, 11'h022,   0, 3);
        add( 50, 1, 4'h1, 11'h066, 0, 0, 0, 1, 1,   0, 0, 1, 11'h022,  51, 3);
        add( 49, 1, 4'h5, 11'h077, 0, 1, 0, 1, 1,   0, 0, 1, 11'h022, 101, 3);
        add(  0, 1, 4'h5, 11'h023, 0, 0, 0, 1, 1,   1, 0, 1, 11'h023,   0, 3);
        add( 50, 1, 4'h5, 11'h7FE, 0, 0, 0, 1, 1,   1, 0, 0, 11'h7FE,   0, 3);
        add(100, 1, 4'h5, 11'h7FF, 0, 0, 0, 1, 1,   1, 0, 1, 11'h7FF,   0, 3);
        add(104, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 1, 1, 11'h000,   4, 4);
        add( 96, 1, 4'h5, 11'h001, 0, 0, 0, 1, 1,   1, 0, 1, 11'h001,   0, 4);
        add(104, 0, 4'h0, 11'h000, 0, 0, 1, 1, 1,   0, 1, 1, 11'h002,   4, 1);
        add( 96, 1, 4'h5, 11'h003, 0, 0, 0, 1, 1,   1, 0, 1, 11'h003,   0, 1);
        add(104, 1, 4'h5, 11'h004, 0, 0, 0, 1, 1,   1, 0, 1, 11'h004,   0, 1);
        add( 96, 1, 4'h5, 11'h005, 0, 0, 0, 1, 1,   1, 0, 1, 11'h005,   0, 1);
        add( 95, 1, 4'h5, 11'h006, 0, 0, 0, 1, 1,   1, 0, 0, 11'h006,   0, 1);
        add(104, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 0, 0, 11'h006, 105, 1);
        add(  5, 1, 4'h5, 11'h010, 0, 0, 0, 1, 1,   1, 0, 0, 11'h010,   0, 1);
        add(100, 1, 4'h5, 11'h011, 0, 0, 0, 1, 1,   1, 0, 1, 11'h011,   0, 1);
        add( 30, 0, 4'h0, 11'h000, 0, 0, 0, 1, 0,   0, 0, 0, 11'h011,   0, 1);
        add(  5, 1, 4'h5, 11'h040, 0, 0, 0, 1, 0,   0, 0, 0, 11'h011,   0, 1);
        add(  0, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 0, 0, 11'h011,   0, 1);
        add( 10, 1, 4'h5, 11'h041, 0, 0, 0, 1, 1,   1, 0, 0, 11'h041,   0, 1);
        add(100, 1, 4'h5, 11'h042, 0, 0, 0, 0, 1,   0, 0, 0, 11'h041,   0, 1);
        add(  0, 0, 4'h0, 11'h000, 0, 0, 0, 1, 1,   0, 0, 0, 11'h041,   0, 1);
        add(  3, 0, 4'h0, 11'h000, 0, 0, 1, 1, 1,   0, 0, 0, 11'h041,   4, 0);

        sif.SOFRxEnable = 1'b0; sif.fullSpeedRate = 1'b0; sif.RxPktValid = 1'b0;
        sif.RxPID = 4'h0; sif.RxFrameNum = 11'h0; sif.RxCRCError = 1'b0;
        sif.RxBitStuffError = 1'b0; sif.missCountClr = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.fn", 32'(sif.frameNum), 32'h0);
        chk("rst.locked", 32'(sif.SOFLocked), 32'h0);
        chk("rst.timer", 32'(sif.SOFTimer), 32'h0);
        chk("rst.mcnt", 32'(sif.SOFMissCount), 32'h0);
        chk("rst.pulses", {30'd0, sif.SOFRxed, sif.SOFMissed}, 32'h0);
        chk_on = 1'b1;
        rst = 1'b1; sif.SOFRxEnable = 1'b1; sif.fullSpeedRate = 1'b1;

        foreach (tbl[i]) begin
            pkt(tbl[i].gap, tbl[i].vld, tbl[i].pid, tbl[i].fnum, tbl[i].crc, tbl[i].bse,
                tbl[i].clr, tbl[i].en, tbl[i].fs);
            chk($sformatf("tbl%0d.rxed", i),   32'(sif.SOFRxed),      32'(tbl[i].x_rxed));
            chk($sformatf("tbl%0d.missed", i), 32'(sif.SOFMissed),    32'(tbl[i].x_missed));
            chk($sformatf("tbl%0d.locked", i), 32'(sif.SOFLocked),    32'(tbl[i].x_locked));
            chk($sformatf("tbl%0d.fn", i),     32'(sif.frameNum),     32'(tbl[i].x_fn));
            chk($sformatf("tbl%0d.timer", i),  32'(sif.SOFTimer),     32'(tbl[i].x_tmr));
            chk($sformatf("tbl%0d.mcnt", i),   32'(sif.SOFMissCount), 32'(tbl[i].x_mcnt));
        end

        // Reset in the middle of a locked frame.
        pkt(2, 1, 4'h5, 11'h100, 0, 0, 0, 1, 1);
        pkt(100, 1, 4'h5, 11'h101, 0, 0, 0, 1, 1);
        chk("midrst.prelock", 32'(sif.SOFLocked), 32'h1);
        repeat (40) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst.fn", 32'(sif.frameNum), 32'h0);
        chk("midrst.locked", 32'(sif.SOFLocked), 32'h0);
        chk("midrst.timer", 32'(sif.SOFTimer), 32'h0);

        // Frame-number discontinuity while locked.
        pkt(3, 1, 4'h5, 11'h01F, 0, 0, 0, 1, 1);
        pkt(100, 1, 4'h5, 11'h020, 0, 0, 0, 1, 1);
        chk("fchk.lock", 32'(sif.SOFLocked), 32'h1);
        pkt(100, 1, 4'h5, 11'h025, 0, 0, 0, 1, 1);
        chk("fchk.fn", 32'(sif.frameNum), 32'h25);
`ifdef SOF_FRAME_CHECK_EN
        chk("fchk.err", 32'(sif.frameNumErr), 32'h1);
        chk("fchk.locked", 32'(sif.SOFLocked), 32'h0);
`else
        chk("fchk.locked", 32'(sif.SOFLocked), 32'h1);
`endif

        // Random traffic: mostly near-window SOFs, plus early, missing, errored and disable events.
        for (int k = 0; k < 200; k++) begin
            int r, g;
            bit vld, crc, bse, clr, en, fs;
            logic [3:0] pid;
            logic [10:0] f;
            r = int'($urandom_range(0, 19));
            if (r < 12)      g = int'($urandom_range(94, 106));
            else if (r < 14) g = int'($urandom_range(10, 95));
            else if (r < 16) g = int'($urandom_range(150, 420));
            else             g = int'($urandom_range(1, 120));
            vld = (r < 14) || (r >= 16);
            pid = (r == 16) ? 4'h1 : 4'h5;
            crc = ($urandom_range(0, 15) == 0);
            bse = ($urandom_range(0, 15) == 0);
            clr = (r == 19) || ($urandom_range(0, 31) == 0);
            en  = !((r == 18) && ($urandom_range(0, 1) == 0));
            fs  = !((r == 18) && !(en == 1'b0));
            f   = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'(e_fn + 1);
            pkt(g, vld, pid, f, crc, bse, clr, en, fs);
            sif.SOFRxEnable = 1'b1; sif.fullSpeedRate = 1'b1;
        end

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sof_receive.md
Name: sof_receive

Overview:
- Device-side (USB slave) Start-Of-Frame receiver: the far end of the host's SOF transmitter.
- Consumes decoded token packets from the slave packet decoder, extracts and latches the 11-bit frame number, and times the interval between SOFs.
- Declares frame lock, flags missed SOFs, and keeps a predicted frame number running across misses.
- Feeds the slave control/register block and isochronous endpoint logic.

Parameters:
FRAME_TICKS, 16'd48000, clk cycles per 1 ms frame at 48 MHz
TOL, 16'd48, allowed deviation in clk cycles either side of FRAME_TICKS
MAX_MISS, 3, consecutive missed SOFs before lock is abandoned

Ports:
clk  input  1  system clock, 48 MHz
rst  input  1  reset; one clock; reset is synchronous and active-low (rst==0 resets on posedge clk)
SOFRxEnable  input  1  software enable for SOF tracking
fullSpeedRate  input  1  1 = full speed link; 0 = low speed (no SOFs on the bus)
RxPktValid  input  1  single-cycle strobe: decoded packet complete
RxPID  input  4  PID of the decoded packet (SOF = 4'h5)
RxFrameNum  input  11  frame-number field of the packet, valid with RxPktValid
RxCRCError  input  1  CRC5 error on the packet, valid with RxPktValid
RxBitStuffError  input  1  bit-stuff error on the packet, valid with RxPktValid
missCountClr  input  1  synchronous clear of SOFMissCount
frameNum  output  11  last received or predicted frame number
SOFRxed  output  1  single-cycle pulse: valid SOF accepted
SOFMissed  output  1  single-cycle pulse: expected SOF did not arrive
SOFLocked  output  1  frame timing locked
SOFTimer  output  16  clk cycles since the start of the current frame, saturating
SOFMissCount  output  8  total missed SOFs, saturating at 8'hFF

Behaviour:
- Reset: state DISABLED; frameNum 0, SOFRxed 0, SOFMissed 0, SOFLocked 0, SOFTimer 0, SOFMissCount 0, internal consecutive-miss counter 0.
- Valid SOF means: RxPktValid & RxPID==4'h5 & !RxCRCError & !RxBitStuffError. Any other packet, including an errored SOF, is ignored completely.
- Outputs are registered with 1-cycle latency. In the cycle after a valid SOF:
  - SOFRxed=1;
  - frameNum = RxFrameNum;
  - SOFTimer = 0;
  - consecutive-miss counter = 0.
- SOFTimer: increments by 1 every cycle in SEARCH, TRACK and LOCKED; saturates at 16'hFFFF; held at 0 in DISABLED.
- Window limits: EARLY = FRAME_TICKS-TOL, LATE = FRAME_TICKS+TOL.
- States:
  - DISABLED: entered from any state, on the next cycle, when SOFRxEnable==0 or fullSpeedRate==0. Clears SOFTimer, SOFLocked and the consecutive-miss counter; frameNum is retained. Exits to SEARCH when both inputs are 1.
  - SEARCH: first valid SOF -> TRACK.
  - TRACK: valid SOF with EARLY <= SOFTimer <= LATE -> LOCKED (SOFLocked=1 next cycle). Valid SOF with SOFTimer < EARLY -> stay in TRACK, timer restarts. SOFTimer reaching LATE+1 with no SOF -> SEARCH, no miss reported.
  - LOCKED, valid SOF inside the window: stay in LOCKED.
  - LOCKED, valid SOF early (SOFTimer < EARLY): -> TRACK, SOFLocked=0. SOFRxed still pulses and frameNum still updates.
  - LOCKED, SOFTimer == LATE with no valid SOF that cycle: SOFMissed pulse; frameNum <= frameNum+1 (mod 2048, wraps 2047->0); SOFTimer reloads to TOL (predicted frame start); SOFMissCount increments unless already 8'hFF; consecutive-miss counter increments.
  - LOCKED, consecutive-miss counter reaching MAX_MISS: -> SEARCH, SOFLocked=0.
- Simultaneous events:
  - Valid SOF in the same cycle as the LATE threshold: the SOF wins, no miss is recorded.
  - missCountClr in the same cycle as a miss increment: the count becomes 1.
  - Disable in the same cycle as a valid SOF: the SOF is not accepted and the state goes to DISABLED.
- Reset asserted mid-frame: all outputs return to their reset values on the next posedge.

Optional Feature:
SOF_FRAME_CHECK_EN
- Defined: adds output frameNumErr (1 bit, reset 0). In LOCKED, a valid in-window SOF whose RxFrameNum != (frameNum+1) mod 2048 produces:
  - frameNumErr pulse for 1 cycle;
  - frameNum adopts RxFrameNum;
  - state -> TRACK, SOFLocked=0.
- Not defined: no frameNumErr port; the frame number is not compared.

Test Plan:
Bench overrides FRAME_TICKS=100, TOL=4, MAX_MISS=3.
1. Reset, enable at full speed, SOFs with frames 0x10, 0x11 spaced 100 cycles -> SOFRxed pulses each time; SOFLocked=1 after the second SOF; frameNum=0x11.
2. Locked, then SOFs stop -> SOFMissed pulses at timer 104, then at 100-cycle intervals; frameNum 0x12, 0x13, 0x14; SOFMissCount=3; SOFLocked=0 after the third miss; state SEARCH.
3. Locked, SOF with RxCRCError=1 at timer 100, then a good SOF at timer 103 -> errored packet ignored; good SOF accepted; SOFMissed never asserted.
4. Locked at frameNum 0x7FF, SOF missing -> predicted frameNum wraps to 0x000.
5. Locked, SOF arrives at timer 50 -> SOFRxed=1, SOFLocked=0, state TRACK; next SOF 100 cycles later -> relocks.
6. fullSpeedRate=0 mid-frame -> next cycle SOFTimer=0, SOFLocked=0; SOFs ignored. With SOF_FRAME_CHECK_EN: locked at 0x20, SOF carrying 0x25 -> frameNumErr pulse, frameNum=0x25.
